cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Parametrised run/reset/halt controller for the CPU core on each board top.
- Replaces the ad-hoc button synchroniser, reset_seq instance and gated-clock halt logic with one block.
- Debounces NUM_BUTTONS raw board buttons and sequences the CPU reset pulse.
- Produces a CPU clock-enable (no gated clock) with run, single-step and halt-on-exit modes.

Parameters:
- NUM_BUTTONS, 2, number of raw buttons. Button 0 is reset request; button 1 is step. Minimum 1.
- DEBOUNCE_CYCLES, 270000, cycles a synchronised input must stay changed before the debounced level follows it. Minimum 2.
- RESET_DELAY_CYCLES, 16, cycles cpu_reset is held after entering RESET. Minimum 1.
- BUTTON_ACTIVE_LOW, 1, 1 = raw button pressed when low.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset; puts every flop in its reset state immediately
- button_in  in  NUM_BUTTONS  raw asynchronous buttons
- exit_in  in  1  CPU exit indication, sampled each cycle
- step_mode  in  1  1 = single-step mode requested
- button_level  out  NUM_BUTTONS  debounced level, active-high = pressed
- button_press  out  NUM_BUTTONS  one-cycle pulse on debounced 0->1
- cpu_reset  out  1  active-high reset to the core
- cpu_clock_enable  out  1  core advances when 1
- halted  out  1  1 while in HALT
- state  out  2  FSM state: RESET=0, RUN=1, STEP_WAIT=2, HALT=3

Behaviour:
- Reset values: button_level=0, button_press=0, state=RESET, cpu_reset=1, cpu_clock_enable=0, halted=0. Delay counter=0; debounce counters=0; synchronisers hold the unpressed value.
- Per button:
  - Invert the raw input if BUTTON_ACTIVE_LOW, then pass it through a 2-flop synchroniser.
  - Debounce counter: when sync != level it increments; when sync == level it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, level <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
  - button_press = level rose this cycle. It is registered and asserts in the cycle after level changes.
- Latency, raw edge to press pulse: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- FSM. Priority in every state: button_press[0] first, then exit_in, then step/mode.
  - RESET: cpu_reset=1, enable=0. Counter counts 0..RESET_DELAY_CYCLES-1. On the last count: to STEP_WAIT if step_mode, else to RUN. exit_in is ignored in RESET.
  - RUN: cpu_reset=0, enable=1.
    - exit_in -> HALT. The enable drops the next cycle, so the core sees at most the exit cycle itself.
    - step_mode=1 -> STEP_WAIT.
  - STEP_WAIT: enable = button_press[1] (combinational from the registered pulse), so exactly one core cycle per press.
    - exit_in -> HALT; if a step pulse arrives in the same cycle, enable is forced 0.
    - step_mode=0 -> RUN.
  - HALT: enable=0, halted=1. Leaves only on button_press[0] or reset.
  - button_press[0] in any state, including RESET -> RESET with the counter reloaded to 0. A press mid-reset extends the reset.
- If NUM_BUTTONS==1, the step button is absent: button_press[1] is treated as 0, so STEP_WAIT only exits via mode change, exit or reset.
- cpu_reset, enable and halted are decoded from registered state; the only combinational term is the step pulse gating.
- Asserting async reset mid-sequence: all outputs return to reset values immediately; the sequence restarts on deassertion.

Optional Feature:
- Macro CPU_RUN_CTRL_STEP_EN.
- Defined: step_mode and button 1 behave as above; STEP_WAIT is reachable.
- Undefined: step_mode is ignored; RESET always goes to RUN; STEP_WAIT is unreachable and needs no logic; button_press[1] remains a plain debounced output.

Test Plan (DEBOUNCE_CYCLES=4, RESET_DELAY_CYCLES=3, BUTTON_ACTIVE_LOW=1, NUM_BUTTONS=2):
- Release async reset with buttons high -> cpu_reset=1 for exactly 3 cycles, then state=RUN, cpu_clock_enable=1, halted=0.
- Drive button_in[0] low for 3 cycles, then high -> no button_press[0], state stays RUN. Hold low for 8 cycles -> one button_press[0] pulse at cycle 7 after the edge, then cpu_reset=1 for 3 cycles.
- In RUN, pulse exit_in for 1 cycle -> state=HALT next cycle, enable=0, halted=1. Later exit pulses leave HALT unchanged; a button 0 press returns to RESET then RUN.
- With the macro defined and step_mode=1 -> STEP_WAIT. Three button 1 presses -> exactly three single-cycle enable pulses. Drop step_mode -> RUN with enable=1.
- In STEP_WAIT, exit_in coincides with button_press[1] -> enable stays 0, state=HALT.
- Assert async reset during RESET count 1 and mid-debounce -> all outputs at reset values the same cycle; after release the full 3-cycle reset is repeated and debounce restarts from 0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// CPU run/reset/halt controller: button debounce, reset sequencing and a core clock-enable.
// Optional single-step mode is compiled in when CPU_RUN_CTRL_STEP_EN is defined.
module cpu_run_ctrl #(
  parameter int NUM_BUTTONS        = 2,
  parameter int DEBOUNCE_CYCLES    = 270000,
  parameter int RESET_DELAY_CYCLES = 16,
  parameter bit BUTTON_ACTIVE_LOW  = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_in,
  input  logic                   exit_in,
  input  logic                   step_mode,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic                   cpu_reset,
  output logic                   cpu_clock_enable,
  output logic                   halted,
  output logic [1:0]             state
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RD_W = (RESET_DELAY_CYCLES > 1) ? $clog2(RESET_DELAY_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(RESET_DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_HALT      = 2'd3
  } state_t;

  logic [NUM_BUTTONS-1:0] pressed_raw;
  assign pressed_raw = BUTTON_ACTIVE_LOW ? ~button_in : button_in;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
    logic            sync_a;
    logic            sync_b;
    logic            level;
    logic            level_prev;
    logic            press;
    logic [DB_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync_a     <= 1'b0;
        sync_b     <= 1'b0;
        level      <= 1'b0;
        level_prev <= 1'b0;
        press      <= 1'b0;
        count      <= '0;
      end else begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the sync chain really is two stages.
        sync_a     <= pressed_raw[i];
        sync_b     <= sync_a;
        level_prev <= level;
        press      <= level & ~level_prev;
        if (sync_b != level) begin
          if (count == DB_LAST) begin
            level <= sync_b;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          count <= '0;
        end
      end
    end

    assign button_level[i] = level;
    assign button_press[i] = press;
  end

`ifdef CPU_RUN_CTRL_STEP_EN
  logic step_press;
  if (NUM_BUTTONS > 1) begin : g_step
    assign step_press = button_press[1];
  end else begin : g_no_step
    assign step_press = 1'b0;
  end
`else
  logic unused_step_mode;
  assign unused_step_mode = step_mode;
`endif

  state_t          cur_state;
  state_t          nxt_state;
  logic [RD_W-1:0] delay_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state   <= ST_RESET;
      delay_count <= '0;
    end else begin
      cur_state <= nxt_state;
      // A reset press reloads the count, so pressing mid-reset stretches the pulse.
      if (cur_state != ST_RESET || button_press[0] || delay_count == RD_LAST) begin
        delay_count <= '0;
      end else begin
        delay_count <= delay_count + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns nxt_state and no latch is inferred.
    nxt_state = cur_state;
    if (button_press[0]) begin
      nxt_state = ST_RESET;
    end else begin
      case (cur_state)
        ST_RESET: begin
          if (delay_count == RD_LAST) begin
`ifdef CPU_RUN_CTRL_STEP_EN
            nxt_state = step_mode ? ST_STEP_WAIT : ST_RUN;
`else
            nxt_state = ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          if (exit_in) begin
            nxt_state = ST_HALT;
          end
`ifdef CPU_RUN_CTRL_STEP_EN
          else if (step_mode) begin
            nxt_state = ST_STEP_WAIT;
          end
`endif
        end
`ifdef CPU_RUN_CTRL_STEP_EN
        ST_STEP_WAIT: begin
          if (exit_in) begin
            nxt_state = ST_HALT;
          end else if (!step_mode) begin
            nxt_state = ST_RUN;
          end
        end
`endif
        default: nxt_state = cur_state;
      endcase
    end
  end

  assign cpu_reset = (cur_state == ST_RESET);
  assign halted    = (cur_state == ST_HALT);
  assign state     = cur_state;

  // The step pulse is the only combinational term; an exit in the same cycle suppresses it.
`ifdef CPU_RUN_CTRL_STEP_EN
  assign cpu_clock_enable = (cur_state == ST_RUN) ||
                            ((cur_state == ST_STEP_WAIT) && step_press && !exit_in);
`else
  assign cpu_clock_enable = (cur_state == ST_RUN);
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset sequencing, debounce, halt, single-step, async reset.
module tb_cpu_run_ctrl;
  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 3;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic [NB-1:0] button_in = '1;
  logic          exit_in   = 1'b0;
  logic          step_mode = 1'b0;
  logic [NB-1:0] button_level;
  logic [NB-1:0] button_press;
  logic          cpu_reset;
  logic          cpu_clock_enable;
  logic          halted;
  logic [1:0]    state;

  int tests_run    = 0;
  int tests_failed = 0;
  int en_count     = 0;

  // {state, cpu_reset, cpu_clock_enable, halted}
  localparam logic [4:0] V_RESET = 5'b00100;
  localparam logic [4:0] V_RUN   = 5'b01010;
  localparam logic [4:0] V_STEP  = 5'b10000;
  localparam logic [4:0] V_HALT  = 5'b11001;

  cpu_run_ctrl #(
    .NUM_BUTTONS       (NB),
    .DEBOUNCE_CYCLES   (DB),
    .RESET_DELAY_CYCLES(RD),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .button_in       (button_in),
    .exit_in         (exit_in),
    .step_mode       (step_mode),
    .button_level    (button_level),
    .button_press    (button_press),
    .cpu_reset       (cpu_reset),
    .cpu_clock_enable(cpu_clock_enable),
    .halted          (halted),
    .state           (state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (cpu_clock_enable === 1'b1) en_count <= en_count + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Returns in the cycle where button_press[idx] is high.
  task automatic press_start(input int idx);
    button_in[idx] = 1'b0;
    tick(7);
  endtask

  task automatic press_end(input int idx);
    tick(1);
    button_in[idx] = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    button_in = '1;
    tick(2);
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_RESET) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_RESET);
    end
    tests_run++;
    if ({button_level, button_press} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_buttons: got %b want 0000", {button_level, button_press});
    end
    reset = 1'b0;
    for (int i = 0; i < RD; i++) begin
      tests_run++;
      if (cpu_reset !== 1'b1 || state !== 2'd0) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: got cpu_reset=%b state=%0d want 1/0", i, cpu_reset, state);
      end
      tick(1);
    end
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_RUN) begin
      tests_failed++;
      $display("FAIL reset_to_run: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_RUN);
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    button_in[0] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) button_in[0] = 1'b1;
      tick(1);
      if (button_press[0] !== 1'b0 || button_level[0] !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_no_press: got level/press activity=1 want 0");
    end
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL glitch_state: got %0d want 1", state);
    end
  endtask

  task automatic test_press_reset();
    logic early = 1'b0;
    button_in[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i < 7 && button_press[0] !== 1'b0) early = 1'b1;
      if (i == 5) begin
        tests_run++;
        if (button_level[0] !== 1'b0) begin
          tests_failed++;
          $display("FAIL debounce_level_early: got %b want 0", button_level[0]);
        end
      end
      if (i == 6) begin
        tests_run++;
        if (button_level[0] !== 1'b1) begin
          tests_failed++;
          $display("FAIL debounce_level: got %b want 1", button_level[0]);
        end
      end
    end
    tests_run++;
    if (early !== 1'b0 || button_press[0] !== 1'b1 || state !== 2'd1) begin
      tests_failed++;
      $display("FAIL press_latency: got early=%b press=%b state=%0d want 0/1/1", early, button_press[0], state);
    end
    press_end(0);
    tests_run++;
    if (button_press[0] !== 1'b0 || state !== 2'd0) begin
      tests_failed++;
      $display("FAIL press_pulse_reset: got press=%b state=%0d want 0/0", button_press[0], state);
    end
    for (int i = 0; i < RD; i++) begin
      tests_run++;
      if (cpu_reset !== 1'b1) begin
        tests_failed++;
        $display("FAIL press_reset_hold cycle %0d: got %b want 1", i, cpu_reset);
      end
      tick(1);
    end
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_RUN) begin
      tests_failed++;
      $display("FAIL press_back_to_run: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_RUN);
    end
    tick(6);
    tests_run++;
    if (button_level[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_level: got %b want 0", button_level[0]);
    end
  endtask

  task automatic test_exit_halt();
    exit_in = 1'b1;
    #1;
    tests_run++;
    if (cpu_clock_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL exit_cycle_enable: got %b want 1", cpu_clock_enable);
    end
    tick(1);
    exit_in = 1'b0;
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_HALT) begin
      tests_failed++;
      $display("FAIL exit_to_halt: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_HALT);
    end
    tick(2);
    exit_in = 1'b1;
    tick(1);
    exit_in = 1'b0;
    tick(1);
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_HALT) begin
      tests_failed++;
      $display("FAIL halt_sticky: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_HALT);
    end
    press_start(0);
    press_end(0);
    tests_run++;
    if (state !== 2'd0) begin
      tests_failed++;
      $display("FAIL halt_to_reset: got %0d want 0", state);
    end
    tick(RD);
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_RUN) begin
      tests_failed++;
      $display("FAIL halt_reset_run: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_RUN);
    end
    tick(6);
  endtask

`ifdef CPU_RUN_CTRL_STEP_EN
  task automatic test_step();
    int base;
    step_mode = 1'b1;
    tick(1);
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_STEP) begin
      tests_failed++;
      $display("FAIL step_enter: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_STEP);
    end
    base = en_count;
    for (int p = 0; p < 3; p++) begin
      press_start(1);
      tests_run++;
      if (cpu_clock_enable !== 1'b1) begin
        tests_failed++;
        $display("FAIL step_pulse %0d: got %b want 1", p, cpu_clock_enable);
      end
      press_end(1);
      tick(8);
    end
    tests_run++;
    if (en_count - base !== 3) begin
      tests_failed++;
      $display("FAIL step_count: got %0d want 3", en_count - base);
    end
    step_mode = 1'b0;
    tick(1);
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_RUN) begin
      tests_failed++;
      $display("FAIL step_leave: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_RUN);
    end
  endtask

  task automatic test_step_exit();
    int base;
    step_mode = 1'b1;
    tick(1);
    base = en_count;
    press_start(1);
    exit_in = 1'b1;
    #1;
    tests_run++;
    if (cpu_clock_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_exit_enable: got %b want 0", cpu_clock_enable);
    end
    tick(1);
    exit_in = 1'b0;
    button_in[1] = 1'b1;
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_HALT) begin
      tests_failed++;
      $display("FAIL step_exit_halt: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_HALT);
    end
    tick(8);
    tests_run++;
    if (en_count - base !== 0) begin
      tests_failed++;
      $display("FAIL step_exit_count: got %0d want 0", en_count - base);
    end
    step_mode = 1'b0;
    press_start(0);
    press_end(0);
    tick(RD);
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL step_exit_recover: got %0d want 1", state);
    end
    tick(6);
  endtask
`else
  task automatic test_step_ignored();
    step_mode = 1'b1;
    tick(3);
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted} !== V_RUN) begin
      tests_failed++;
      $display("FAIL step_ignored: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_RUN);
    end
    press_start(1);
    tests_run++;
    if (button_press[1] !== 1'b1 || cpu_clock_enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL step_button_plain: got press=%b en=%b want 1/1", button_press[1], cpu_clock_enable);
    end
    press_end(1);
    tests_run++;
    if (state !== 2'd1) begin
      tests_failed++;
      $display("FAIL step_button_state: got %0d want 1", state);
    end
    step_mode = 1'b0;
    tick(8);
  endtask
`endif

  task automatic test_async_reset();
    button_in[0] = 1'b0;
    tick(4);
    button_in[1] = 1'b0;
    tick(3);
    tests_run++;
    if (button_press[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_setup_press: got %b want 1", button_press[0]);
    end
    tick(1);
    button_in[0] = 1'b1;
    tick(1);
    tests_run++;
    if (state !== 2'd0 || button_level[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_setup_mid: got state=%0d level1=%b want 0/0", state, button_level[1]);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({state, cpu_reset, cpu_clock_enable, halted, button_level, button_press} !== {V_RESET, 4'b0000}) begin
      tests_failed++;
      $display("FAIL async_reset_now: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted, button_level, button_press}, {V_RESET, 4'b0000});
    end
    tick(2);
    reset = 1'b0;
    for (int t = 0; t <= 7; t++) begin
      if (t < RD) begin
        tests_run++;
        if (cpu_reset !== 1'b1) begin
          tests_failed++;
          $display("FAIL async_rerun_hold cycle %0d: got %b want 1", t, cpu_reset);
        end
      end
      if (t == RD) begin
        tests_run++;
        if ({state, cpu_reset, cpu_clock_enable, halted} !== V_RUN) begin
          tests_failed++;
          $display("FAIL async_rerun_run: got %b want %b", {state, cpu_reset, cpu_clock_enable, halted}, V_RUN);
        end
      end
      if (t == 5 || t == 6) begin
        tests_run++;
        if (button_level[1] !== (t == 6)) begin
          tests_failed++;
          $display("FAIL async_debounce_restart t=%0d: got %b want %b", t, button_level[1], (t == 6));
        end
      end
      if (t == 7) begin
        tests_run++;
        if (button_press[1] !== 1'b1) begin
          tests_failed++;
          $display("FAIL async_debounce_press: got %b want 1", button_press[1]);
        end
      end
      if (t < 7) tick(1);
    end
    button_in[1] = 1'b1;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_reset();
    test_exit_halt();
`ifdef CPU_RUN_CTRL_STEP_EN
    test_step();
    test_step_exit();
`else
    test_step_ignored();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
